// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP-RISC ALU divide path.
package kgp_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for a zero divisor: every bit is this value (all ones).
  localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/cla_subtractor_wide.sv
// WIDTH-bit subtractor a - b built as a + ~b + 1 on 4-bit CLA slices
// with a lookahead carry unit across the slices. borrow = NOT carry-out.
module cla_subtractor_wide #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NS = WIDTH / 4;

  logic [WIDTH-1:0] bn;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NS-1:0]    sg;
  logic [NS-1:0]    sp;
  logic [NS:0]      gc;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Group generate/propagate of each augmented 4-bit slice
  always_comb begin
    sg = '0;
    sp = '0;
    for (int k = 0; k < NS; k++) begin
      sg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      sp[k] = &p[4*k +: 4];
    end
  end

  // Lookahead carry unit across slices, then carries inside each slice
  always_comb begin
    gc    = '0;
    c     = '0;
    gc[0] = 1'b1;
    for (int k = 0; k < NS; k++) begin
      gc[k+1] = sg[k] | (sp[k] & gc[k]);
    end
    for (int k = 0; k < NS; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign diff   = p ^ c;
  assign borrow = ~gc[NS];

endmodule

// File: rtl/seq_divider_unit.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned,
// with a start/busy/done handshake and divide-by-zero bypass.
module seq_divider_unit
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             bypass;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] s_a, s_b, s_diff;
  logic             s_borrow;
  logic [WIDTH-1:0] n_b, n_diff;
  logic             unused_borrow;
  logic             take;
  logic             dvd_neg, dvs_neg;

  assign r_sh    = {r[WIDTH-2:0], dq[WIDTH-1]};
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  // A bit shifted out of r means r' >= 2^WIDTH > |divisor|: subtraction always fits.
  assign take    = r[WIDTH-1] | ~s_borrow;
  assign busy    = (state != IDLE);

  // Operand routing for the shared subtractors: magnitudes in IDLE, trial
  // subtraction in RUN, sign-fix negation (0 - x) in FIX
  always_comb begin
    s_a = '0;
    s_b = dividend;
    n_b = divisor;
    case (state)
      RUN: begin
        s_a = r_sh;
        s_b = dvs;
        n_b = r;
      end
      FIX: begin
        s_b = dq;
        n_b = r;
      end
      default: ;
    endcase
  end

  cla_subtractor_wide #(.WIDTH(WIDTH)) u_step_sub (
    .a      (s_a),
    .b      (s_b),
    .diff   (s_diff),
    .borrow (s_borrow)
  );

  cla_subtractor_wide #(.WIDTH(WIDTH)) u_neg_sub (
    .a      ({WIDTH{1'b0}}),
    .b      (n_b),
    .diff   (n_diff),
    .borrow (unused_borrow)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FIX : RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers and done pulse; cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIX) begin
        done <= 1'b1;
        if (bypass) begin
          quotient    <= {WIDTH{DIV_ZERO_Q_FILL}};
          remainder   <= dq;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= neg_q ? s_diff : dq;
          remainder   <= neg_r ? n_diff : r;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // Working datapath: operand capture and one restoring step per clock
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      if (divisor == '0) begin
        bypass <= 1'b1;
        dq     <= dividend;
      end else begin
        bypass <= 1'b0;
        dq     <= dvd_neg ? s_diff : dividend;
        dvs    <= dvs_neg ? n_diff : divisor;
        neg_q  <= dvd_neg ^ dvs_neg;
        neg_r  <= dvd_neg;
        r      <= '0;
        cnt    <= CNT_W'(WIDTH - 1);
      end
    end else if (state == RUN) begin
      r   <= take ? s_diff : r_sh;
      dq  <= {dq[WIDTH-2:0], take};
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_divider_unit.sv
// Scoreboard bench for seq_divider_unit: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_seq_divider_unit;
  import kgp_alu_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] z;
    string        name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with q=%h r=%h, expected no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        check({e.name, "_quotient"}, quotient, e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_div_by_zero"}, W'(div_by_zero), e.z);
      end
    end
  end

  task automatic do_start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the start edge; returns #1 after the edge that raises done
  task automatic wait_done(input string name, input int exp_lat, input int pulse_at);
    int n = 0;
    bit got = 1'b0;
    bit busy_bad = 1'b0;
    if (busy !== 1'b1) busy_bad = 1'b1;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (n == pulse_at) begin
          start = 1'b1; is_signed = 1'b0; dividend = 9; divisor = 3;
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
    end else begin
      check({name, "_latency"}, W'(n), W'(exp_lat));
      check({name, "_busy_during"}, W'(busy_bad), '0);
      check({name, "_busy_at_done"}, W'(busy), '0);
    end
  endtask

  task automatic run(input string name, input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic z, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.z = W'(z); e.name = name;
    sb.push_back(e);
    do_start(s, a, b);
    wait_done(name, lat, 0);
  endtask

  initial begin
    exp_t e;
    int stray;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dbz", W'(div_by_zero), '0);
    check("reset_done", W'(done), '0);
    check("reset_busy", W'(busy), '0);
    rst = 1'b0;

    run("u100_7",     1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33);
    run("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    run("u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 33);
    run("s_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33);
    run("u5_0",       1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1);
    run("s5_0",       1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1);
    run("s_m5_0",     1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);
    run("u_big_div",  1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1,        32'h7FFFFFFE, 1'b0, 33);
    run("s7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33);
    run("s_m7_m2",    1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33);
    run("u_m7_2",     1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 33);

    // start while busy is ignored, then a start in the done cycle is accepted
    e.q = 32'd100; e.r = 32'd0; e.z = '0; e.name = "busy_ign";
    sb.push_back(e);
    do_start(1'b0, 32'd1000, 32'd10);
    wait_done("busy_ign", 33, 5);
    e.q = 32'd3; e.r = 32'd0; e.z = '0; e.name = "done_cycle";
    sb.push_back(e);
    do_start(1'b0, 32'd9, 32'd3);
    wait_done("done_cycle", 33, 0);

    // reset mid-operation aborts: outputs cleared, no done pulse
    do_start(1'b0, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", W'(div_by_zero), '0);
    check("abort_done", W'(done), '0);
    check("abort_busy", W'(busy), '0);
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) stray++;
    end
    check("abort_no_done", W'(stray), '0);

    run("after_abort", 1'b0, 32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 33);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
